axil_copy_engine: RTL and testbench

- AXI4-Lite master DMA-style engine: copies `len` consecutive DATA_WIDTH words from `src_addr` to `dst_addr`.
- Processes one word at a time: read, then write.
- Sits upstream of the smartconnect on a master slot; source and target are the regbank slaves behind the smartconnect.
- Driven from CSR hardware-interface fields (start, addresses, length); returns busy/done/error status to them.

---
 rtl/axil_copy_engine_if.sv | 43 ++++
 rtl/axil_copy_engine.sv | 202 ++++++++++++++++++++
 tb/tb_axil_copy_engine.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_copy_engine_if.sv
// AXI4-Lite bus bundle between the copy engine (master) and the interconnect slot (slave).
interface Bus2Master_intf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_copy_engine.sv
// AXI4-Lite word-by-word copy engine (read one word, write it, repeat len times).
// Optional AXIL_COPY_ERR_ABORT_EN: abort the job on the first non-OKAY response.
module axil_copy_engine #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  Bus2Master_intf.master        axi4lite2Master_intf,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_resp,
  output logic [LEN_WIDTH-1:0]  words_done
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_RESP, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, words_q, words_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [1:0]            err_resp_q, err_resp_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic                 ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                 r_bad, b_bad;
  logic [LEN_WIDTH-1:0] words_inc;

  assign ar_hs     = arvalid_q & axi4lite2Master_intf.arready;
  assign r_hs      = rready_q  & axi4lite2Master_intf.rvalid;
  assign aw_hs     = awvalid_q & axi4lite2Master_intf.awready;
  assign w_hs      = wvalid_q  & axi4lite2Master_intf.wready;
  assign b_hs      = bready_q  & axi4lite2Master_intf.bvalid;
  assign r_bad     = axi4lite2Master_intf.rresp != 2'b00;
  assign b_bad     = axi4lite2Master_intf.bresp != 2'b00;
  assign words_inc = words_q + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = (len == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (ar_hs) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_hs) begin
`ifdef AXIL_COPY_ERR_ABORT_EN
          state_d = r_bad ? S_DONE : S_WR_REQ;
`else
          state_d = S_WR_REQ;
`endif
        end
      end
      S_WR_REQ:  if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = S_WR_RESP;
      S_WR_RESP: begin
        if (b_hs) begin
`ifdef AXIL_COPY_ERR_ABORT_EN
          if (b_bad) state_d = S_DONE;
          else
`endif
          state_d = (words_inc == len_q) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Job registers, response capture and registered bus outputs decoded from the next state.
  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    words_d    = words_q;
    data_d     = data_q;
    err_d      = err_q;
    err_resp_d = err_resp_q;
    aw_done_d  = 1'b0;
    w_done_d   = 1'b0;

    if (state_q == S_IDLE && start) begin
      src_d      = src_addr;
      dst_d      = dst_addr;
      len_d      = len;
      words_d    = '0;
      err_d      = 1'b0;
      err_resp_d = 2'b00;
    end
    if (state_q == S_RD_WAIT && r_hs) begin
      data_d = axi4lite2Master_intf.rdata;
      if (r_bad) begin
        err_d = 1'b1;
        if (!err_q) err_resp_d = axi4lite2Master_intf.rresp;
      end
    end
    if (state_q == S_WR_REQ) begin
      aw_done_d = aw_done_q | aw_hs;
      w_done_d  = w_done_q | w_hs;
    end
    if (state_q == S_WR_RESP && b_hs) begin
      if (b_bad) begin
        err_d = 1'b1;
        if (!err_q) err_resp_d = axi4lite2Master_intf.bresp;
      end
`ifdef AXIL_COPY_ERR_ABORT_EN
      if (!b_bad) begin
`else
      begin
`endif
        words_d = words_inc;
        src_d   = src_q + STEP;
        dst_d   = dst_q + STEP;
      end
    end

    arvalid_d = state_d == S_RD_REQ;
    rready_d  = state_d == S_RD_WAIT;
    awvalid_d = (state_d == S_WR_REQ) && !aw_done_d;
    wvalid_d  = (state_d == S_WR_REQ) && !w_done_d;
    wstrb_d   = wvalid_d ? '1 : '0;
    bready_d  = state_d == S_WR_RESP;
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = state_d == S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      words_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_resp_q <= 2'b00;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wstrb_q    <= '0;
      bready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      words_q    <= words_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_resp_q <= err_resp_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wstrb_q    <= wstrb_d;
      bready_q   <= bready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign axi4lite2Master_intf.araddr  = src_q;
  assign axi4lite2Master_intf.arprot  = 3'b000;
  assign axi4lite2Master_intf.arvalid = arvalid_q;
  assign axi4lite2Master_intf.rready  = rready_q;
  assign axi4lite2Master_intf.awaddr  = dst_q;
  assign axi4lite2Master_intf.awprot  = 3'b000;
  assign axi4lite2Master_intf.awvalid = awvalid_q;
  assign axi4lite2Master_intf.wdata   = data_q;
  assign axi4lite2Master_intf.wstrb   = wstrb_q;
  assign axi4lite2Master_intf.wvalid  = wvalid_q;
  assign axi4lite2Master_intf.bready  = bready_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_resp   = err_resp_q;
  assign words_done = words_q;
endmodule

// File: tb/tb_axil_copy_engine.sv
// Bench for axil_copy_engine: table of copy jobs against an AXI4-Lite slave model, plus reset-mid-write sequence.
module tb_axil_copy_engine;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic [1:0]    err_resp;
  logic [LW-1:0] words_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  Bus2Master_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .axi4lite2Master_intf(bus),
    .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err), .err_resp(err_resp), .words_done(words_done)
  );

  // Slave model: ARREADY immediate, AW/W ready after a programmable wait, read data = addr ^ 0xD0000000.
  int          aw_delay = 0, w_delay = 0, aw_cnt, w_cnt;
  bit          rerr_en = 0, berr_en = 0;
  logic [31:0] rerr_addr = '0, berr_addr = '0;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] wr_addr_log[$], wr_data_log[$], rd_addr_log[$];
  int          viol_cnt = 0;

  wire aw_hs_w = bus.awvalid && bus.awready;
  wire w_hs_w  = bus.wvalid && bus.wready;
  wire aw_now  = aw_got || aw_hs_w;
  wire w_now   = w_got || w_hs_w;
  wire [31:0] wa_now = aw_hs_w ? bus.awaddr : aw_addr_l;
  wire [31:0] wd_now = w_hs_w ? bus.wdata : w_data_l;

  assign bus.arready = bus.arvalid;
  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0;
    end else begin
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= bus.araddr ^ 32'hD000_0000;
        bus.rresp  <= (rerr_en && bus.araddr == rerr_addr) ? 2'b10 : 2'b00;
        rd_addr_log.push_back(bus.araddr);
      end
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
      if (aw_hs_w) begin aw_addr_l <= bus.awaddr; aw_got <= 1'b1; end
      if (w_hs_w)  begin w_data_l <= bus.wdata;   w_got  <= 1'b1; end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (aw_now && w_now && (aw_hs_w || w_hs_w)) begin
        wr_addr_log.push_back(wa_now);
        wr_data_log.push_back(wd_now);
        bus.bvalid <= 1'b1;
        bus.bresp  <= (berr_en && wa_now == berr_addr) ? 2'b11 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // A VALID must not re-assert for a channel that already handshook in this write; WSTRB all ones.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.awvalid && aw_got) viol_cnt <= viol_cnt + 1;
      else if (bus.wvalid && w_got) viol_cnt <= viol_cnt + 1;
      else if (bus.wvalid && bus.wstrb != 4'hF) viol_cnt <= viol_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          aw_dly;
    int          w_dly;
    int          rerr_idx;
    int          berr_idx;
    bit          poke;
    int          exp_lat;
    logic [15:0] exp_words;
    logic        exp_err;
    logic [1:0]  exp_resp;
    int          exp_writes;
    int          exp_reads;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int lat;
    int v0;
    bit saw_ar, saw_aw, saw_busy;
    logic [31:0] ea;
    lat = -1; saw_ar = 0; saw_aw = 0; saw_busy = 0;
    aw_delay = v.aw_dly;
    w_delay  = v.w_dly;
    rerr_en  = v.rerr_idx >= 0;
    rerr_addr = v.src + 32'(4 * v.rerr_idx);
    berr_en  = v.berr_idx >= 0;
    berr_addr = v.dst + 32'(4 * v.berr_idx);
    wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
    v0 = viol_cnt;
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        if (v.len != 0) begin
          chk({tag, "/arvalid_1cyc"}, 64'(bus.arvalid), 64'd1);
          chk({tag, "/busy_1cyc"}, 64'(busy), 64'd1);
        end
      end
      if (v.poke && k == 3) begin
        start = 1'b1; src_addr = 32'h9000; dst_addr = 32'hA000; len = 16'd7;
      end
      if (v.poke && k == 4) start = 1'b0;
      saw_ar   |= bus.arvalid;
      saw_aw   |= bus.awvalid;
      saw_busy |= busy;
      if (done) begin lat = k; break; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL %s/timeout: no done pulse within 400 cycles", tag);
    end else if (v.exp_lat >= 0) begin
      chk({tag, "/done_latency"}, 64'(lat), 64'(v.exp_lat));
    end
    @(negedge clk);
    chk({tag, "/done_1pulse"}, 64'(done), 64'd0);
    chk({tag, "/busy_after"}, 64'(busy), 64'd0);
    if (v.len == 0) begin
      chk({tag, "/no_arvalid"}, 64'(saw_ar), 64'd0);
      chk({tag, "/no_awvalid"}, 64'(saw_aw), 64'd0);
      chk({tag, "/no_busy"}, 64'(saw_busy), 64'd0);
    end
    chk({tag, "/words_done"}, 64'(words_done), 64'(v.exp_words));
    chk({tag, "/err"}, 64'(err), 64'(v.exp_err));
    chk({tag, "/err_resp"}, 64'(err_resp), 64'(v.exp_resp));
    chk({tag, "/n_writes"}, 64'(wr_addr_log.size()), 64'(v.exp_writes));
    chk({tag, "/n_reads"}, 64'(rd_addr_log.size()), 64'(v.exp_reads));
    for (int i = 0; i < v.exp_writes && i < wr_addr_log.size(); i++) begin
      ea = v.dst + 32'(4 * i);
      chk($sformatf("%s/wr_addr[%0d]", tag, i), 64'(wr_addr_log[i]), 64'(ea));
      ea = (v.src + 32'(4 * i)) ^ 32'hD000_0000;
      chk($sformatf("%s/wr_data[%0d]", tag, i), 64'(wr_data_log[i]), 64'(ea));
    end
    for (int i = 0; i < v.exp_reads && i < rd_addr_log.size(); i++) begin
      ea = v.src + 32'(4 * i);
      chk($sformatf("%s/rd_addr[%0d]", tag, i), 64'(rd_addr_log[i]), 64'(ea));
    end
    chk({tag, "/protocol_viol"}, 64'(viol_cnt - v0), 64'd0);
  endtask

  initial begin
    vec_t vecs[8];
    bit   found;

    //             src           dst           len    awd wd rerr berr poke lat words err resp wr rd
    vecs[0] = '{32'h1000,     32'h2000,     16'd4, 0, 0, -1, -1, 0, 17, 16'd4, 0, 2'b00, 4, 4};
    vecs[1] = '{32'h1000,     32'h2000,     16'd0, 0, 0, -1, -1, 0,  1, 16'd0, 0, 2'b00, 0, 0};
    vecs[2] = '{32'h3000,     32'h4000,     16'd1, 3, 0, -1, -1, 0, -1, 16'd1, 0, 2'b00, 1, 1};
    vecs[3] = '{32'h3000,     32'h4000,     16'd1, 0, 3, -1, -1, 0, -1, 16'd1, 0, 2'b00, 1, 1};
`ifdef AXIL_COPY_ERR_ABORT_EN
    vecs[4] = '{32'h1000,     32'h5000,     16'd4, 0, 0,  2, -1, 0, -1, 16'd2, 1, 2'b10, 2, 3};
    vecs[6] = '{32'h6000,     32'h7000,     16'd3, 0, 0, -1,  1, 0, -1, 16'd1, 1, 2'b11, 2, 2};
`else
    vecs[4] = '{32'h1000,     32'h5000,     16'd4, 0, 0,  2, -1, 0, -1, 16'd4, 1, 2'b10, 4, 4};
    vecs[6] = '{32'h6000,     32'h7000,     16'd3, 0, 0, -1,  1, 0, -1, 16'd3, 1, 2'b11, 3, 3};
`endif
    vecs[5] = '{32'hFFFF_FFFC, 32'h0100,    16'd2, 0, 0, -1, -1, 0, 9, 16'd2, 0, 2'b00, 2, 2};
    vecs[7] = '{32'h1000,     32'h2000,     16'd4, 0, 0, -1, -1, 1, 17, 16'd4, 0, 2'b00, 4, 4};

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    chk("rst/arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst/awvalid", 64'(bus.awvalid), 64'd0);
    chk("rst/wvalid", 64'(bus.wvalid), 64'd0);
    chk("rst/rready", 64'(bus.rready), 64'd0);
    chk("rst/bready", 64'(bus.bready), 64'd0);
    chk("rst/araddr", 64'(bus.araddr), 64'd0);
    chk("rst/awaddr", 64'(bus.awaddr), 64'd0);
    chk("rst/wdata", 64'(bus.wdata), 64'd0);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/err", 64'(err), 64'd0);
    chk("rst/err_resp", 64'(err_resp), 64'd0);
    chk("rst/words_done", 64'(words_done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Reset while the write address channel is stalled.
    aw_delay = 3; w_delay = 0; rerr_en = 0; berr_en = 0;
    @(negedge clk);
    src_addr = 32'h1000; dst_addr = 32'h2000; len = 16'd4; start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.awvalid) begin found = 1; break; end
      @(negedge clk);
    end
    chk("midrst/reached_wr_req", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/awvalid", 64'(bus.awvalid), 64'd0);
    chk("midrst/wvalid", 64'(bus.wvalid), 64'd0);
    chk("midrst/arvalid", 64'(bus.arvalid), 64'd0);
    chk("midrst/busy", 64'(busy), 64'd0);
    chk("midrst/words_done", 64'(words_done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_job(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
